// File: rtl/mpu_poll_seq_pkg.sv
// Shared types and instruction tables for the MPU-6050 poll sequencer.
// Each instruction byte is a pair of 4-bit controller ROM addresses {hi, lo}.
package mpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_CHECK   = 3'd4,
        ST_GAP     = 3'd5,
        ST_FAULT   = 3'd6
    } seq_state_e;

    localparam int TBL_W    = 8;
    localparam int INIT_LEN = 3;
    localparam int POLL_LEN = 7;

    localparam logic [2:0] SLOT_ACCEL_X = 3'd0;
    localparam logic [2:0] SLOT_ACCEL_Y = 3'd1;
    localparam logic [2:0] SLOT_ACCEL_Z = 3'd2;
    localparam logic [2:0] SLOT_TEMP    = 3'd3;
    localparam logic [2:0] SLOT_GYRO_X  = 3'd4;
    localparam logic [2:0] SLOT_GYRO_Y  = 3'd5;
    localparam logic [2:0] SLOT_GYRO_Z  = 3'd6;

    // PWR_MGMT_1 wake, SMPRT_DIV, CONFIG
    localparam logic [TBL_W-1:0] INIT_TABLE [INIT_LEN] = '{8'h01, 8'h23, 8'h45};
    // ACCEL_X, ACCEL_Y, ACCEL_Z, TEMP, GYRO_X, GYRO_Y, GYRO_Z burst pairs
    localparam logic [TBL_W-1:0] POLL_TABLE [POLL_LEN] =
        '{8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34};

    function automatic logic [TBL_W-1:0] table_instr(input logic poll, input logic [2:0] idx);
        logic [TBL_W-1:0] r;
        r = 8'h00;
        if (poll) begin
            case (idx)
                SLOT_ACCEL_X: r = POLL_TABLE[0];
                SLOT_ACCEL_Y: r = POLL_TABLE[1];
                SLOT_ACCEL_Z: r = POLL_TABLE[2];
                SLOT_TEMP:    r = POLL_TABLE[3];
                SLOT_GYRO_X:  r = POLL_TABLE[4];
                SLOT_GYRO_Y:  r = POLL_TABLE[5];
                SLOT_GYRO_Z:  r = POLL_TABLE[6];
                default:      r = 8'h00;
            endcase
        end else begin
            case (idx)
                3'd0:    r = INIT_TABLE[0];
                3'd1:    r = INIT_TABLE[1];
                3'd2:    r = INIT_TABLE[2];
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/mpu_poll_seq_edge_det.sv
// Rising-edge detector with a registered history bit; input is already synchronous.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic prev_r;

    // Previous-cycle sample of the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= din;
        end
    end

    assign rise = din & ~prev_r;

endmodule

// File: rtl/mpu_poll_seq.sv
// Sequencer driving the MPU-6050 I2C controller: one-shot init list, then a
// periodic poll list with per-instruction retry, timeout and sticky fault.
module mpu_poll_seq
    import mpu_seq_pkg::*;
#(
    parameter int FPGA_CLK    = 50_000_000,
    parameter int INSTR_SZ    = 8,
    parameter int RXD_SZ      = 24,
    parameter int N_INIT      = 3,
    parameter int N_POLL      = 7,
    parameter int POLL_PERIOD = FPGA_CLK / 1000,
    parameter int TIMEOUT     = FPGA_CLK / 500,
    parameter int MAX_RETRY   = 3
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic                I_START,
    input  logic                I_BUSY,
    input  logic                I_ERR,
    input  logic                I_ACK_FL,
    input  logic [RXD_SZ-1:0]   I_RXD,
    output logic                O_EN,
    output logic [INSTR_SZ-1:0] O_INSTR,
    output logic [15:0]         O_SAMPLE,
    output logic [2:0]          O_SLOT,
    output logic                O_VLD,
    output logic                O_ROUND,
    output logic                O_INIT_DONE,
    output logic                O_FAULT,
    output logic                O_BUSY
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int PER_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(POLL_PERIOD - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);

    seq_state_e          state_r, state_s;
    logic [2:0]          idx_r, idx_s;
    logic                poll_r, poll_s;
    logic [RTY_W-1:0]    retry_r, retry_s;
    logic                err_seen_r, err_seen_s;
    logic [TMO_W-1:0]    tmo_r, tmo_s;
    logic [PER_W-1:0]    per_r;
    logic                per_run_r, pend_r;
    logic                err_rise_s, ack_rise_s, err_any_s;
    logic                last_s, wrap_s, tmo_hit_s;
    logic                en_s, vld_s, round_s, init_done_s, fault_s, busy_s;
    logic [INSTR_SZ-1:0] instr_s;
    logic [15:0]         sample_s;
    logic [2:0]          slot_s;
    logic                rxd_unused_s;

    edge_det u_err_edge (.clk(CLK), .rst_n(RST_n), .din(I_ERR),    .rise(err_rise_s));
    edge_det u_ack_edge (.clk(CLK), .rst_n(RST_n), .din(I_ACK_FL), .rise(ack_rise_s));

    // Coincident controller error and ACK-failure edges are one error.
    assign err_any_s    = err_rise_s | ack_rise_s;
    assign tmo_hit_s    = (tmo_r == TMO_LAST);
    assign wrap_s       = per_run_r && (per_r == PER_LAST);
    assign last_s       = poll_r ? (idx_r == 3'(N_POLL - 1)) : (idx_r == 3'(N_INIT - 1));
    assign rxd_unused_s = ^I_RXD[RXD_SZ-1:16];

    // Sequencer state register and per-instruction bookkeeping.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_r    <= ST_IDLE;
            idx_r      <= 3'd0;
            poll_r     <= 1'b0;
            retry_r    <= {RTY_W{1'b0}};
            err_seen_r <= 1'b0;
            tmo_r      <= {TMO_W{1'b0}};
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            poll_r     <= poll_s;
            retry_r    <= retry_s;
            err_seen_r <= err_seen_s;
            tmo_r      <= tmo_s;
        end
    end

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        poll_s      = poll_r;
        retry_s     = retry_r;
        err_seen_s  = err_seen_r;
        tmo_s       = tmo_r;
        vld_s       = 1'b0;
        round_s     = 1'b0;
        sample_s    = O_SAMPLE;
        slot_s      = O_SLOT;
        init_done_s = O_INIT_DONE;
        fault_s     = O_FAULT;
        case (state_r)
            ST_IDLE: begin
                if (I_START) begin
                    state_s = ST_ISSUE;
                    idx_s   = 3'd0;
                    poll_s  = O_INIT_DONE;
                    retry_s = {RTY_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                err_seen_s = 1'b0;
                tmo_s      = {TMO_W{1'b0}};
                state_s    = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                err_seen_s = err_seen_r | err_any_s;
                if (tmo_hit_s) begin
                    err_seen_s = 1'b1;
                    state_s    = ST_CHECK;
                end else if (I_BUSY) begin
                    tmo_s   = {TMO_W{1'b0}};
                    state_s = ST_WAIT_LO;
                end else begin
                    tmo_s = tmo_r + TMO_W'(1);
                end
            end
            ST_WAIT_LO: begin
                err_seen_s = err_seen_r | err_any_s;
                if (tmo_hit_s) begin
                    err_seen_s = 1'b1;
                    state_s    = ST_CHECK;
                end else if (!I_BUSY) begin
                    state_s = ST_CHECK;
                end else begin
                    tmo_s = tmo_r + TMO_W'(1);
                end
            end
            ST_CHECK: begin
                if (!err_seen_r) begin
                    retry_s = {RTY_W{1'b0}};
                    if (poll_r) begin
                        sample_s = I_RXD[15:0];
                        slot_s   = idx_r;
                        vld_s    = 1'b1;
                    end else begin
                        sample_s = O_SAMPLE;
                    end
                    if (last_s) begin
                        if (poll_r) begin
                            round_s = 1'b1;
                        end else begin
                            init_done_s = 1'b1;
                        end
                        state_s = ST_GAP;
                    end else begin
                        idx_s   = idx_r + 3'd1;
                        state_s = ST_ISSUE;
                    end
                    if (!I_START) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = state_s;
                    end
                end else if (retry_r < RTY_LIMIT) begin
                    retry_s = retry_r + RTY_W'(1);
                    state_s = ST_ISSUE;
                end else begin
                    fault_s = 1'b1;
                    state_s = ST_FAULT;
                end
            end
            ST_GAP: begin
                // Before the first poll round the period counter is idle; start at once.
                if (!I_START) begin
                    state_s = ST_IDLE;
                end else if (!per_run_r || wrap_s || pend_r) begin
                    state_s = ST_ISSUE;
                    poll_s  = 1'b1;
                    idx_s   = 3'd0;
                    retry_s = {RTY_W{1'b0}};
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_FAULT: begin
                state_s = ST_FAULT;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        en_s    = (state_s == ST_ISSUE);
        busy_s  = (state_s != ST_IDLE) && (state_s != ST_FAULT);
        if (en_s) begin
            instr_s = INSTR_SZ'(table_instr(poll_s, idx_s));
        end else begin
            instr_s = O_INSTR;
        end
    end

    // Poll period counter; a wrap seen outside GAP is held so an overrun round still starts.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            per_r     <= {PER_W{1'b0}};
            per_run_r <= 1'b0;
            pend_r    <= 1'b0;
        end else if (state_s == ST_IDLE) begin
            per_r     <= {PER_W{1'b0}};
            per_run_r <= 1'b0;
            pend_r    <= 1'b0;
        end else if (!per_run_r) begin
            per_r     <= {PER_W{1'b0}};
            per_run_r <= (state_s == ST_ISSUE) && poll_s;
            pend_r    <= 1'b0;
        end else begin
            per_r <= wrap_s ? {PER_W{1'b0}} : per_r + PER_W'(1);
            if ((state_r == ST_GAP) && (state_s == ST_ISSUE)) begin
                pend_r <= 1'b0;
            end else if (wrap_s) begin
                pend_r <= 1'b1;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            O_EN        <= 1'b0;
            O_INSTR     <= {INSTR_SZ{1'b0}};
            O_SAMPLE    <= 16'h0000;
            O_SLOT      <= 3'd0;
            O_VLD       <= 1'b0;
            O_ROUND     <= 1'b0;
            O_INIT_DONE <= 1'b0;
            O_FAULT     <= 1'b0;
            O_BUSY      <= 1'b0;
        end else begin
            O_EN        <= en_s;
            O_INSTR     <= instr_s;
            O_SAMPLE    <= sample_s;
            O_SLOT      <= slot_s;
            O_VLD       <= vld_s;
            O_ROUND     <= round_s;
            O_INIT_DONE <= init_done_s;
            O_FAULT     <= fault_s;
            O_BUSY      <= busy_s;
        end
    end

endmodule

// File: tb/tb_mpu_poll_seq.sv
// Randomized scoreboard bench for mpu_poll_seq with a behavioural controller model.
module tb_mpu_poll_seq;

    localparam int PER      = 500;
    localparam int TMO      = 200;
    localparam int BUSY_LEN = 20;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        I_START = 1'b0;
    logic        I_BUSY = 1'b0;
    logic        I_ERR = 1'b0;
    logic        I_ACK_FL = 1'b0;
    logic [23:0] I_RXD = 24'h000000;
    logic        O_EN;
    logic [7:0]  O_INSTR;
    logic [15:0] O_SAMPLE;
    logic [2:0]  O_SLOT;
    logic        O_VLD, O_ROUND, O_INIT_DONE, O_FAULT, O_BUSY;

    mpu_poll_seq #(.POLL_PERIOD(PER), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST_n(RST_n), .I_START(I_START), .I_BUSY(I_BUSY),
        .I_ERR(I_ERR), .I_ACK_FL(I_ACK_FL), .I_RXD(I_RXD),
        .O_EN(O_EN), .O_INSTR(O_INSTR), .O_SAMPLE(O_SAMPLE), .O_SLOT(O_SLOT),
        .O_VLD(O_VLD), .O_ROUND(O_ROUND), .O_INIT_DONE(O_INIT_DONE),
        .O_FAULT(O_FAULT), .O_BUSY(O_BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] instr;
        bit         poll;
        int         idx;
    } exp_en_t;

    exp_en_t     exp_en_q[$];
    logic [18:0] exp_vld_q[$];
    int          t_round_q[$];
    int          t_en_q[$];

    int total = 0, bad = 0;
    int cyc = 0;
    int scen = 0, epoch = 0;
    bit m_poll = 1'b0, m_fault = 1'b0;
    int m_idx = 0, m_try = 0, m_round = 0;
    int n_en = 0, n_vld = 0, n_round = 0;
    int busy_k = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [7:0] ref_instr(input bit poll, input int idx);
        logic [7:0] init_t [3];
        logic [7:0] poll_t [7];
        init_t = '{8'h01, 8'h23, 8'h45};
        poll_t = '{8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34};
        return poll ? poll_t[idx] : init_t[idx];
    endfunction

    // 0 ok, 1 I_ERR pulse, 2 I_ACK_FL pulse, 3 both at once, 4 busy never rises
    function automatic int plan(input bit poll, input int idx, input int tr, input int rnd);
        case (scen)
            1: begin
                if (poll && idx == 3 && tr == 0 && rnd == 1) return 2;
                if (poll && idx == 5 && tr == 0 && rnd == 2) return 3;
                return 0;
            end
            2: return (!poll && idx == 1) ? 1 : 0;
            3: return (!poll && idx == 0) ? 4 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_en();
        exp_en_t e;
        e.instr = ref_instr(m_poll, m_idx);
        e.poll  = m_poll;
        e.idx   = m_idx;
        exp_en_q.push_back(e);
    endtask

    task automatic model_start();
        exp_en_q.delete();
        exp_vld_q.delete();
        m_poll = 1'b0; m_idx = 0; m_try = 0; m_round = 0; m_fault = 1'b0;
        push_en();
    endtask

    task automatic model_result(input bit ok, input logic [15:0] smp);
        if (ok) begin
            if (m_poll) exp_vld_q.push_back({3'(m_idx), smp});
            m_try = 0;
            if (m_poll && m_idx == 6) begin
                m_round++;
                m_idx = 0;
            end else if (!m_poll && m_idx == 2) begin
                m_poll = 1'b1;
                m_idx  = 0;
            end else begin
                m_idx++;
            end
            push_en();
        end else if (m_try < 3) begin
            m_try++;
            push_en();
        end else begin
            m_fault = 1'b1;
        end
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        I_START = 1'b0;
        epoch++;
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        n_en = 0; n_vld = 0; n_round = 0;
        t_round_q.delete();
        t_en_q.delete();
        @(negedge CLK);
    endtask

    // Controller model: answers each O_EN with a busy window and a reading.
    initial begin : ctl
        int mode, ep, pulse_at;
        bit aborted;
        logic [15:0] smp;
        forever begin
            @(negedge CLK);
            if (RST_n && O_EN) begin
                ep   = epoch;
                mode = plan(m_poll, m_idx, m_try, m_round);
                if (mode == 4) begin
                    model_result(1'b0, 16'h0000);
                end else begin
                    smp      = (m_poll && m_idx == 2) ? 16'h3FA2 : 16'($urandom);
                    pulse_at = int'($urandom_range(2, BUSY_LEN - 3));
                    aborted  = 1'b0;
                    I_BUSY   = 1'b1;
                    for (int k = 0; k < BUSY_LEN; k++) begin
                        I_ERR    = (k == pulse_at) && (mode == 1 || mode == 3);
                        I_ACK_FL = (k == pulse_at) && (mode == 2 || mode == 3);
                        busy_k   = k;
                        @(negedge CLK);
                        if (ep != epoch) begin
                            aborted = 1'b1;
                            break;
                        end
                    end
                    I_ERR    = 1'b0;
                    I_ACK_FL = 1'b0;
                    if (!aborted) begin
                        I_RXD = {8'($urandom), smp};
                        model_result(mode == 0, smp);
                    end
                    I_BUSY = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents O_EN or O_VLD.
    initial begin : mon
        exp_en_t e;
        logic [18:0] v;
        forever begin
            @(negedge CLK);
            if (RST_n) begin
                if (O_EN) begin
                    n_en++;
                    t_en_q.push_back(cyc);
                    if (exp_en_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_en: got instr %0h expected no enable", O_INSTR);
                    end else begin
                        e = exp_en_q.pop_front();
                        chk("instr", 32'(O_INSTR), 32'(e.instr));
                        if (e.poll && e.idx == 0) t_round_q.push_back(cyc);
                    end
                end
                if (O_VLD) begin
                    n_vld++;
                    if (exp_vld_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_vld: got slot %0d sample %0h expected none", O_SLOT, O_SAMPLE);
                    end else begin
                        v = exp_vld_q.pop_front();
                        chk("slot_sample", 32'({O_SLOT, O_SAMPLE}), 32'(v));
                    end
                end
                if (O_ROUND) n_round++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int g;
        // Scenario 1: reset state, init, three poll rounds with retries, stop.
        scen = 1;
        repeat (3) @(negedge CLK);
        chk("rst_flags", 32'({O_EN, O_VLD, O_ROUND, O_INIT_DONE, O_FAULT, O_BUSY, O_SLOT}), 32'h0);
        chk("rst_data", 32'({O_INSTR, O_SAMPLE}), 32'h0);
        RST_n = 1'b1;
        @(negedge CLK);
        model_start();
        I_START = 1'b1;
        for (int i = 0; i < 5000 && n_round < 3; i++) @(negedge CLK);
        chk("rounds", 32'(n_round), 32'd3);
        I_START = 1'b0;
        repeat (600) @(negedge CLK);
        chk("stop_busy", 32'(O_BUSY), 32'd0);
        chk("init_done", 32'(O_INIT_DONE), 32'd1);
        chk("no_fault", 32'(O_FAULT), 32'd0);
        chk("vld_count", 32'(n_vld), 32'd21);
        chk("vld_left", 32'(exp_vld_q.size()), 32'd0);
        chk("en_count", 32'(n_en), 32'd26);
        chk("en_left", 32'(exp_en_q.size()), 32'd1);
        chk("round_starts", 32'(t_round_q.size()), 32'd3);
        if (t_round_q.size() >= 3) begin
            chk("period_1", 32'(t_round_q[1] - t_round_q[0]), 32'(PER));
            chk("period_2", 32'(t_round_q[2] - t_round_q[1]), 32'(PER));
        end

        // Scenario 2: init entry 1 fails every attempt.
        scen = 2;
        do_reset();
        model_start();
        I_START = 1'b1;
        for (int i = 0; i < 3000 && !O_FAULT; i++) @(negedge CLK);
        chk("err_fault", 32'(O_FAULT), 32'd1);
        chk("err_busy", 32'(O_BUSY), 32'd0);
        chk("err_en_count", 32'(n_en), 32'd5);
        chk("err_model_fault", 32'(m_fault), 32'd1);
        g = n_en;
        repeat (1000) @(negedge CLK);
        chk("err_quiet", 32'(n_en), 32'(g));
        chk("err_no_init_done", 32'(O_INIT_DONE), 32'd0);

        // Scenario 3: busy never rises, every attempt times out.
        scen = 3;
        do_reset();
        model_start();
        I_START = 1'b1;
        for (int i = 0; i < 3000 && !O_FAULT; i++) @(negedge CLK);
        chk("tmo_fault", 32'(O_FAULT), 32'd1);
        chk("tmo_en_count", 32'(n_en), 32'd4);
        if (t_en_q.size() >= 2) begin
            g = t_en_q[1] - t_en_q[0];
            chk("tmo_gap", 32'((g >= TMO) && (g <= TMO + 4)), 32'd1);
        end

        // Scenario 4: reset pulse mid-WAIT_LO, then restart repeats the init list.
        scen = 0;
        do_reset();
        model_start();
        I_START = 1'b1;
        for (int i = 0; i < 3000 && !(m_poll && m_idx == 1 && I_BUSY && busy_k == 10); i++)
            @(negedge CLK);
        chk("pre_rst_init_done", 32'(O_INIT_DONE), 32'd1);
        RST_n = 1'b0;
        I_START = 1'b0;
        epoch++;
        @(negedge CLK);
        chk("mid_rst_flags", 32'({O_EN, O_VLD, O_ROUND, O_INIT_DONE, O_FAULT, O_BUSY, O_SLOT}), 32'h0);
        chk("mid_rst_data", 32'({O_INSTR, O_SAMPLE}), 32'h0);
        RST_n = 1'b1;
        repeat (5) @(negedge CLK);
        chk("post_rst_idle", 32'({O_BUSY, O_EN}), 32'h0);
        n_en = 0; n_vld = 0; n_round = 0;
        model_start();
        I_START = 1'b1;
        for (int i = 0; i < 1000 && !O_INIT_DONE; i++) @(negedge CLK);
        chk("restart_init_done", 32'(O_INIT_DONE), 32'd1);
        chk("restart_init_en", 32'(n_en), 32'd3);
        I_START = 1'b0;
        repeat (300) @(negedge CLK);
        chk("restart_stop", 32'(O_BUSY), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpu_poll_seq.md
Name: mpu_poll_seq

Overview:
- Upstream sequencer for the MPU-6050 I2C controller top.
- After I_START it issues a fixed init instruction list once, then repeats a poll list every POLL_PERIOD clocks.
- Drives the controller's enable and 8-bit instruction inputs, and waits on its busy output.
- Captures each returned 16-bit reading, tags it with a slot index, retries failed instructions, and latches a fault after repeated failures.

Parameters:
- FPGA_CLK, 50_000_000, clock frequency in Hz; used only to derive the defaults below.
- INSTR_SZ, 8, instruction width: two 4-bit ROM addresses.
- RXD_SZ, 24, controller receive buffer width.
- N_INIT, 3, number of entries in the init list.
- N_POLL, 7, number of poll entries: accel X/Y/Z, temp, gyro X/Y/Z.
- POLL_PERIOD, 50_000, clocks from one poll-round start to the next (1 kHz).
- TIMEOUT, 100_000, maximum clocks spent in any single wait state.
- MAX_RETRY, 3, retries per instruction before fault.

Ports:
- CLK  in  1  system clock
- RST_n  in  1  asynchronous active-low reset
- I_START  in  1  level; 1 = run, 0 = stop at the next instruction boundary
- I_BUSY  in  1  controller busy
- I_ERR  in  1  controller FSM error
- I_ACK_FL  in  1  controller I2C ACK error
- I_RXD  in  RXD_SZ  controller receive buffer
- O_EN  out  1  one-cycle enable pulse to the controller
- O_INSTR  out  INSTR_SZ  instruction to the controller; held stable from the O_EN pulse until completion
- O_SAMPLE  out  16  last captured reading, signed
- O_SLOT  out  3  poll index of O_SAMPLE (0..N_POLL-1)
- O_VLD  out  1  one-cycle pulse when O_SAMPLE/O_SLOT update
- O_ROUND  out  1  one-cycle pulse after the last poll slot completes
- O_INIT_DONE  out  1  sticky; set when the init list completes
- O_FAULT  out  1  sticky; set when retries are exhausted
- O_BUSY  out  1  high in every state except IDLE and FAULT

Behaviour:
- Reset: state IDLE; all outputs 0; all counters 0; index 0.
- The reset is asynchronous and may arrive mid-transaction; the block returns to IDLE with no further O_EN.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, CHECK, GAP, FAULT.
- IDLE:
  - I_START=1 and O_INIT_DONE=0 -> ISSUE with the init list, index 0.
  - I_START=1 and O_INIT_DONE=1 -> ISSUE with the poll list, index 0.
- ISSUE:
  - Load O_INSTR from the table entry and assert O_EN for exactly one cycle.
  - Clear the error-seen flag and the timeout counter -> WAIT_HI.
- WAIT_HI: wait for I_BUSY=1, then -> WAIT_LO.
  - Exception: I_BUSY already 1 on the cycle after O_EN is accepted as the rising edge.
- WAIT_LO: on I_BUSY=0 -> CHECK.
- Error tracking: a rising edge of I_ERR or I_ACK_FL during WAIT_HI or WAIT_LO sets the error-seen flag.
- Timeout: the counter reaching TIMEOUT-1 in WAIT_HI or WAIT_LO sets the error-seen flag and forces -> CHECK.
- CHECK, error-seen = 0:
  - Poll list: O_SAMPLE <= I_RXD[15:0] (high byte in [15:8]), O_SLOT <= index, O_VLD pulses this cycle.
  - Init list: no capture.
  - Retry count cleared.
  - If more entries remain: index+1 -> ISSUE.
  - Else, init list: set O_INIT_DONE -> GAP.
  - Else, poll list: pulse O_ROUND -> GAP.
- CHECK, error-seen = 1:
  - If retry < MAX_RETRY: retry+1, reissue the same index -> ISSUE.
  - Otherwise: set O_FAULT -> FAULT.
  - Failed entries never pulse O_VLD.
- Period counter:
  - Free-runs from the cycle the first poll ISSUE starts.
  - Reloads on reaching POLL_PERIOD-1.
- GAP:
  - Waits for the period counter to wrap, then -> ISSUE with the poll list, index 0.
  - An overrun (round longer than POLL_PERIOD) starts the next round immediately; no round is skipped silently.
- I_START=0:
  - Checked only in GAP and in CHECK on success; goes -> IDLE.
  - An in-flight instruction always completes.
- FAULT: terminal until reset; O_EN is held 0.
- Simultaneous events: I_ERR and I_ACK_FL edges on the same cycle count as one error.
- Counter widths: $clog2 of each bound; the period counter saturates correctly when POLL_PERIOD=1.

Decomposition:
- Package mpu_seq_pkg holds:
  - state encoding;
  - INIT_TABLE[N_INIT] and POLL_TABLE[N_POLL] as INSTR_SZ constants (ROM address pairs: PWR_MGMT_1 wake, SMPRT_DIV, CONFIG; then ACCEL_X..GYRO_Z burst pairs);
  - slot index constants.
- One sub-module, edge_det: registered rising-edge detector, instanced for I_ERR and I_ACK_FL.

Test Plan:
- Reset, then I_START=1; the controller model holds busy for 20 clocks per instruction.
  - Required: 3 init O_EN pulses with table values, O_INIT_DONE=1.
  - Then 7 O_VLD pulses, slots 0..6, each O_SAMPLE equal to the model's I_RXD[15:0] (e.g. 16'h3FA2 on slot 2).
  - Then O_ROUND.
- POLL_PERIOD=500: the second-round first O_EN lands exactly 500 clocks after the first-round first O_EN.
- I_ACK_FL pulse on slot 3, first attempt only.
  - Required: slot 3 reissued once with identical O_INSTR, exactly one O_VLD for slot 3, O_FAULT=0.
- I_ERR pulses on every attempt of init entry 1 -> 4 attempts total, then O_FAULT=1, O_BUSY=0, no further O_EN for 1000 clocks.
- Busy never rises -> TIMEOUT elapses, retry issued; after 4 timeouts O_FAULT=1.
- Mid-WAIT_LO RST_n low for 1 clock -> all outputs 0 including the sticky flags; restart repeats the init list.
